// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Definitions shared by the UART receiver and transmitter: data
//            width, default bit period and the receiver state encoding.
// Config   : none (the receiver's optional parity uses UART_RX_PARITY_EN)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   // Payload width of one character.
   localparam int DATA_BITS = 8;

   // 100 MHz clock / 115200 baud.
   localparam int DEFAULT_CLKS_PER_BIT = 868;

   // Receiver states. PARITY is only visited when parity is compiled in.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } uart_rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : 1-bit, two-stage synchronizer for bringing an asynchronous level
//            into the clk domain. RST_VAL selects the value both stages take
//            during reset (use 1 for idle-high lines).
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops; the first may go metastable, the second settles it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : UART receiver. Recovers 8N1 frames (or 8E1 with parity) from the
//            rx pin using mid-bit sampling driven by a clock-cycle divider.
//            Good bytes appear on data with a one-cycle valid strobe; a low
//            stop bit gives a one-cycle frame_err strobe and the receiver then
//            waits for the line to return high before looking for a new start.
// Config   : define UART_RX_PARITY_EN for 8E1 (even parity, parity_err strobe);
//            leave undefined for 8N1 with parity_err tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT  // must be >= 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int             CW          = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  c_cnt_last  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  c_cnt_half  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  c_cnt_one   = CW'(1);
   localparam logic [2:0]     c_bit_last  = 3'(DATA_BITS - 1);

   logic                 rx_s;

   uart_rx_state_t       state_q, state_d;
   logic [CW-1:0]        cnt_q,   cnt_d;
   logic [2:0]           bit_q,   bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q,  data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q,  ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                 perr_q,  perr_d;
   logic                 pmis_q,  pmis_d;
`endif

   // Idle-high line: the synchronizer resets to 1 so reset never looks like a start bit.
   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync_rx (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   // Next-state, bit timing, shifting and strobe generation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + c_cnt_one;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
      pmis_d  = pmis_q;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            // Half a bit in: a line that is high again was only a glitch.
            if (cnt_q == c_cnt_half) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
                  bit_d   = 3'd0;
               end
            end
         end
         ST_DATA: begin
            if (cnt_q == c_cnt_last) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            // Even parity: data bits XOR parity bit must be zero.
            if (cnt_q == c_cnt_last) begin
               cnt_d   = '0;
               pmis_d  = (^shift_q) ^ rx_s;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_q == c_cnt_last) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                  perr_d  = pmis_q;
`endif
                  state_d = ST_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // A line stuck low must go high before another frame is accepted.
            cnt_d = '0;
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, timing and output registers; reset discards any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
         pmis_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q  <= perr_d;
         pmis_q  <= pmis_d;
`endif
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire
